mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Control unit for the multicycle RV32I datapath: an FSM that sequences fetch, decode, execute,
//  memory and writeback, driving every mux select, register enable and the ALU operation code.
//  Sits beside the datapath inside riscvmulti; consumes Instr fields and Zero.
//  Traps on unsupported instructions.
// PARAMETERS
//  none. The encodings are fixed by the datapath and are not configurable.
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  asynchronous, active-low reset (0 = reset)
//  op          in   7  Instr[6:0]
//  funct3      in   3  Instr[14:12]
//  funct7b5    in   1  Instr[30]
//  Zero        in   1  ALU zero flag
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 A
//  ALUSrcB     out  2  00 WriteData, 01 ImmExt, 10 const 4
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  AdrSrc      out  1  0 PC, 1 Result
//  ALUControl  out  3  000 add, 001 sub, 101 slt, 011 or, 010 and, 111 sll, 100 srl, 110 sra
//  IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  enables
//  Illegal     out  1  sticky trap flag
// BEHAVIOUR
//  - The state register is the only storage. All outputs are combinational (Moore) from state.
//    Exceptions: ImmSrc (decoded from op at all times) and PCWrite (= PCUpdate | Branch & taken).
//  - Reset (async): state <= FETCH immediately, including mid-instruction.
//    Outputs then show the FETCH values; Illegal = 0.
//  - Unlisted selects are 00 and unlisted enables are 0. ALUOp is 00 add, 01 sub, 10 funct.
//  - FETCH:  AdrSrc 0, IRWrite 1, SrcA 00, SrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
//    Next state: DECODE.
//  - DECODE: SrcA 01, SrcB 01, ALUOp 00 (branch/jal target -> ALUOut). Next state by op:
//    0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH,
//    1101111 -> JAL, 1100111 -> JALR1.
//    Goes to TRAP instead on: any other op; a branch with funct3 not 000/001;
//    an R- or I-type with funct3 011 or 100.
//  - MEMADR: SrcA 10, SrcB 01, ALUOp 00. Next: MEMREAD if op[5]=0, else MEMWRITE.
//  - MEMREAD: ResultSrc 00, AdrSrc 1 -> MEMWB. MEMWB: ResultSrc 01, RegWrite 1 -> FETCH.
//  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 -> FETCH.
//  - EXECR: SrcA 10, SrcB 00, ALUOp 10 -> ALUWB. EXECI: SrcA 10, SrcB 01, ALUOp 10 -> ALUWB.
//  - ALUWB: ResultSrc 00, RegWrite 1 -> FETCH.
//  - BRANCH: SrcA 10, SrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
//    taken = Zero when funct3=000 (beq), ~Zero when funct3=001 (bne). Next: FETCH.
//  - JAL: SrcA 01, SrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB (rd <= OldPC+4).
//  - JALR1: SrcA 10, SrcB 01, ALUOp 00 -> JALR2.
//  - JALR2: SrcA 01, SrcB 10, ResultSrc 00, PCUpdate 1 -> ALUWB.
//  - TRAP: all enables 0, Illegal 1. Held until reset.
//  - ALU decode:
//    - ALUOp 00 -> add; ALUOp 01 -> sub.
//    - ALUOp 10 by funct3: 000 gives sub when op[5] & funct7b5, else add;
//      010 slt, 110 or, 111 and, 001 sll; 101 gives sra when funct7b5, else srl.
//  - Cycles per instruction: lw 5; sw, R, I, jal 4; jalr 5; branch 3 (counting FETCH).
// STRUCTURE
//  - Package rv_ctrl_pkg holds:
//    - statetype enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
//      ALUWB, BRANCH, JAL, JALR1, JALR2, TRAP);
//    - opcode localparams;
//    - ALUControl and mux-select localparams.
//  - Sub-module alu_dec (op[5], funct3, funct7b5, ALUOp -> ALUControl) is combinational.
//    The FSM and the ImmSrc decode stay in mc_controller.
// TESTING
//  - reset=0 mid-MEMREAD -> same cycle: state FETCH, IRWrite 1, PCWrite 1, Illegal 0.
//  - add (0x00B50533) after reset release -> FETCH, DECODE, EXECR (ALUControl 000), ALUWB
//    (RegWrite 1); back in FETCH on cycle 5.
//  - sub (funct7b5=1, R-type) -> ALUControl 001 in EXECR.
//  - srai (op 0010011, f3 101, f7b5 1) -> 110 in EXECI.
//  - lw -> 5 cycles: MemWrite never 1; AdrSrc 1 in MEMREAD; ResultSrc 01 with RegWrite 1 in MEMWB.
//  - sw -> MemWrite 1 only in cycle 4.
//  - beq: Zero=1 -> PCWrite 1 in BRANCH; Zero=0 -> PCWrite 0.
//  - bne: inverse of beq.
//  - op 0110111 (lui) -> TRAP after DECODE: Illegal 1, no enables for 10 cycles.
//    reset clears Illegal.
//  - In top with riscvtest.txt -> memory write of 25 to address 100; "Simulation succeeded".

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM state type,
// opcodes, ALU operation codes and datapath mux-select values. The encodings
// are fixed by the datapath and are not meant to be configured.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR1,
        JALR2,
        TRAP
    } statetype;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALUOp: coarse operation requested by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes understood by the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    // Mux selects
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: turns the FSM's ALUOp plus instruction fields into the ALU
// operation code. Purely combinational.
//   op5_i         Instr[5]: distinguishes R-type (1) from I-type (0)
//   funct3_i      Instr[14:12]
//   funct7b5_i    Instr[30]
//   alu_op_i      00 add, 01 sub, 10 decode from funct fields
//   alu_control_o ALU operation code
module alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o
);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 is an immediate bit for addi, so only R-type subtracts
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    3'b001:  alu_control_o = ALU_SLL;
                    // srai carries funct7b5 in its immediate, so it applies to I-type too
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Control unit for the multicycle RV32I datapath. A Moore FSM sequences
// fetch/decode/execute/memory/writeback and drives all mux selects, enables
// and the ALU operation code. Unsupported instructions park the FSM in TRAP.
//   clk, reset             rising-edge clock, async active-low reset
//   op, funct3, funct7b5   instruction fields
//   Zero                   ALU zero flag, used for beq/bne
//   ImmSrc                 immediate format, decoded from op at all times
//   ALUSrcA/ALUSrcB        ALU operand selects
//   ResultSrc, AdrSrc      result and memory-address selects
//   ALUControl             ALU operation
//   IRWrite, PCWrite, RegWrite, MemWrite  enables
//   Illegal                high while trapped (held until reset)
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Illegal
);
    import rv_ctrl_pkg::*;

    statetype   state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       taken;
    logic       bad_alu_f3;

    // NOTE: sequential state uses non-blocking assignment; reset is
    // asynchronous so FETCH takes effect immediately, even mid-instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // funct3 011 and 100 have no matching ALU operation
    assign bad_alu_f3 = (funct3 == 3'b011) || (funct3 == 3'b100);

    always_comb begin
        state_d   = state_q;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WDATA;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        alu_op    = ALUOP_ADD;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                pc_update = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                // Precompute branch/jal target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = bad_alu_f3 ? TRAP : EXECR;
                    OP_ITYPE:          state_d = bad_alu_f3 ? TRAP : EXECI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR1;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                state_d = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = FETCH;
            end
            EXECR: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = FETCH;
            end
            JAL, JALR2: begin
                // Jump target already sits in ALUOut; ALU forms OldPC+4 for rd
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            JALR1: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                state_d = JALR2;
            end
            TRAP: begin
                Illegal = 1'b1;
            end
            default: state_d = TRAP;
        endcase
    end

    // beq takes on Zero, bne on ~Zero; other funct3 values never reach BRANCH
    assign taken   = funct3[0] ? ~Zero : Zero;
    assign PCWrite = pc_update | (branch & taken);

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_dec u_alu_dec (
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_op_i      (alu_op),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the
// FSM cycle by cycle and compares every output against hand-built vectors.
// Vector layout: {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
//                 IRWrite, PCWrite, RegWrite, MemWrite, Illegal}
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
    logic [16:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Illegal    (Illegal)
    );

    assign obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                  IRWrite, PCWrite, RegWrite, MemWrite, Illegal};

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011, BR = 7'b1100011, JALOP = 7'b1101111;
    localparam logic [6:0] JALROP = 7'b1100111, LUI = 7'b0110111;

    // Per-state output vectors without ImmSrc:
    // {SrcA, SrcB, ResultSrc, AdrSrc, ALUControl, IR, PC, Reg, Mem, Illegal}
    localparam logic [14:0] S_F    = {2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 5'b11000};
    localparam logic [14:0] S_D    = {2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] S_MA   = {2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] S_MR   = {2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 5'b00000};
    localparam logic [14:0] S_MWB  = {2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 5'b00100};
    localparam logic [14:0] S_MWR  = {2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 5'b00010};
    localparam logic [14:0] S_AWB  = {2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 5'b00100};
    localparam logic [14:0] S_JMP  = {2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 5'b01000};
    localparam logic [14:0] S_J1   = {2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 5'b00000};
    localparam logic [14:0] S_TRAP = {2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 5'b00001};

    function automatic logic [14:0] s_exr(input logic [2:0] ctl);
        return {2'b10, 2'b00, 2'b00, 1'b0, ctl, 5'b00000};
    endfunction

    function automatic logic [14:0] s_exi(input logic [2:0] ctl);
        return {2'b10, 2'b01, 2'b00, 1'b0, ctl, 5'b00000};
    endfunction

    function automatic logic [14:0] s_br(input logic tk);
        return {2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, tk, 3'b000};
    endfunction

    // Leaves the DUT in FETCH, 1 time unit after a rising edge.
    task automatic do_reset(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z);
        @(posedge clk); #1;
        reset = 1'b0; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] exp_q [$];
        // While reset is asserted the outputs show FETCH
        reset = 1'b0; op = LOAD; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        #1;
        vectors++;
        if (obs !== {2'b00, S_F}) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", obs, {2'b00, S_F});
        end
        // Run lw into MEMREAD, then pull reset mid-cycle
        do_reset(LOAD, 3'b010, 1'b0, 1'b0);
        exp_q = '{{2'b00, S_F}, {2'b00, S_D}, {2'b00, S_MA}, {2'b00, S_MR}};
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_lw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            if (i < exp_q.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (obs !== {2'b00, S_F}) begin
            miscompares++;
            $display("FAIL reset_mid_memread: got %b expected %b", obs, {2'b00, S_F});
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0]  ops [3] = '{RTYPE, RTYPE, ITYPE};
        logic        f7s [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [3] = '{3'b000, 3'b000, 3'b101};
        logic [14:0] exs [3];
        logic [16:0] exp_q [$];
        exs[0] = s_exr(3'b000);   // add
        exs[1] = s_exr(3'b001);   // sub
        exs[2] = s_exi(3'b110);   // srai
        for (int t = 0; t < 3; t++) begin
            do_reset(ops[t], f3s[t], f7s[t], 1'b0);
            exp_q = '{{2'b00, S_F}, {2'b00, S_D}, {2'b00, exs[t]}, {2'b00, S_AWB}, {2'b00, S_F}};
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                vectors++;
                if (obs !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL alu_op%0d cycle %0d: got %b expected %b", t, i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_lw();
        logic [16:0] exp_q [$];
        do_reset(LOAD, 3'b010, 1'b0, 1'b0);
        exp_q = '{{2'b00, S_F}, {2'b00, S_D}, {2'b00, S_MA}, {2'b00, S_MR},
                  {2'b00, S_MWB}, {2'b00, S_F}};
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q [$];
        // add then sw with no reset in between
        do_reset(RTYPE, 3'b000, 1'b0, 1'b0);
        exp_q = '{{2'b00, S_F}, {2'b00, S_D}, {2'b00, s_exr(3'b000)}, {2'b00, S_AWB},
                  {2'b01, S_F}, {2'b01, S_D}, {2'b01, S_MA}, {2'b01, S_MWR}, {2'b01, S_F}};
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 4) op = STORE;
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL add_then_sw cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic        zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        tks [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [16:0] exp_q [$];
        for (int t = 0; t < 4; t++) begin
            do_reset(BR, f3s[t], 1'b0, zs[t]);
            exp_q = '{{2'b10, S_F}, {2'b10, S_D}, {2'b10, s_br(tks[t])}, {2'b10, S_F}};
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                vectors++;
                if (obs !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL branch f3=%b zero=%b cycle %0d: got %b expected %b",
                             f3s[t], zs[t], i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jumps();
        logic [16:0] exp_q [$];
        do_reset(JALOP, 3'b000, 1'b0, 1'b0);
        exp_q = '{{2'b11, S_F}, {2'b11, S_D}, {2'b11, S_JMP}, {2'b11, S_AWB}, {2'b11, S_F}};
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL jal cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        do_reset(JALROP, 3'b000, 1'b0, 1'b0);
        exp_q = '{{2'b00, S_F}, {2'b00, S_D}, {2'b00, S_J1}, {2'b00, S_JMP},
                  {2'b00, S_AWB}, {2'b00, S_F}};
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL jalr cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [6:0]  ops  [4] = '{LUI, RTYPE, ITYPE, BR};
        logic [2:0]  f3s  [4] = '{3'b000, 3'b011, 3'b100, 3'b100};
        logic [1:0]  imms [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
        logic [16:0] exp_q [$];
        for (int t = 0; t < 4; t++) begin
            do_reset(ops[t], f3s[t], 1'b0, 1'b1);
            exp_q = '{{imms[t], S_F}, {imms[t], S_D}};
            // lui is held in TRAP for 10 cycles, the others briefly
            for (int k = 0; k < ((t == 0) ? 10 : 2); k++) exp_q.push_back({imms[t], S_TRAP});
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                vectors++;
                if (obs !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL trap op=%b f3=%b cycle %0d: got %b expected %b",
                             ops[t], f3s[t], i, obs, exp_q[i]);
                end
                @(posedge clk); #1;
            end
            // Reset clears the trap at once
            reset = 1'b0;
            #1;
            vectors++;
            if (obs !== {imms[t], S_F}) begin
                miscompares++;
                $display("FAIL trap_clear op=%b: got %b expected %b", ops[t], obs, {imms[t], S_F});
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_lw();
        test_back_to_back();
        test_branch();
        test_jumps();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
